// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, flag bit positions, default width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Bit positions inside the 4-bit flags vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational RV-style ALU. Carry is the carry-out for ADD and the borrow
// (rs1 < rs2 unsigned) for SUB; overflow is signed overflow for ADD/SUB.
// Both are zero for every other op. Zero/sign always reflect rd.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic [3:0]      flags,
  input  logic [3:0]      ALUControl
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   diff_s;
  logic [SHW-1:0]  shamt_s;
  logic            ovf_s;
  logic            cry_s;

  assign sum_s   = {1'b0, rs1} + {1'b0, rs2};
  assign diff_s  = {1'b0, rs1} - {1'b0, rs2};
  assign shamt_s = rs2[SHW-1:0];

  // Operation select plus flag generation.
  always_comb begin
    rd    = {XLEN{1'b0}};
    ovf_s = 1'b0;
    cry_s = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        rd    = sum_s[XLEN-1:0];
        cry_s = sum_s[XLEN];
        ovf_s = (rs1[XLEN-1] == rs2[XLEN-1]) && (sum_s[XLEN-1] != rs1[XLEN-1]);
      end
      ALU_SUB: begin
        rd    = diff_s[XLEN-1:0];
        cry_s = diff_s[XLEN];
        ovf_s = (rs1[XLEN-1] != rs2[XLEN-1]) && (diff_s[XLEN-1] != rs1[XLEN-1]);
      end
      ALU_SLL:  rd = rs1 << shamt_s;
      ALU_SLT:  rd = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      ALU_SLTU: rd = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      ALU_XOR:  rd = rs1 ^ rs2;
      ALU_SRL:  rd = rs1 >> shamt_s;
      ALU_SRA:  rd = $signed(rs1) >>> shamt_s;
      ALU_OR:   rd = rs1 | rs2;
      ALU_AND:  rd = rs1 & rs2;
      default:  rd = {XLEN{1'b0}};
    endcase
    flags         = 4'b0000;
    flags[FLAG_V] = ovf_s;
    flags[FLAG_C] = cry_s;
    flags[FLAG_Z] = (rd == {XLEN{1'b0}});
    flags[FLAG_S] = rd[XLEN-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant among
// requesters whose response slot can take a result, one-deep registered
// response slot per requester, and a saturating contention counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0][XLEN-1:0]  req_a,
  input  logic [1:0][XLEN-1:0]  req_b,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][XLEN-1:0]  rsp_result,
  output logic [1:0][3:0]       rsp_flags,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]            slot_free_s;
  logic [1:0]            eligible_s;
  logic [1:0]            grant_s;
  logic                  sel_s;
  logic [XLEN-1:0]       alu_rd_s;
  logic [3:0]            alu_flags_s;

  logic                  rr_ptr_r;
  logic [1:0]            rsp_valid_r;
  logic [1:0][XLEN-1:0]  rsp_result_r;
  logic [1:0][3:0]       rsp_flags_r;
  logic [CNT_W-1:0]      conflict_cnt_r;

  // A slot can accept when empty or being drained this cycle.
  assign slot_free_s = ~rsp_valid_r | rsp_ready;
  assign eligible_s  = req_valid & slot_free_s;

  // Work-conserving round-robin: rr_ptr only matters when both are eligible.
  always_comb begin
    grant_s = 2'b00;
    case (eligible_s)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  // Requester 0 feeds the ALU whenever requester 1 is not granted.
  assign sel_s     = grant_s[1];
  assign req_ready = grant_s;

  alu #(.XLEN(XLEN)) u_alu (
    .rs1        (req_a[sel_s]),
    .rs2        (req_b[sel_s]),
    .rd         (alu_rd_s),
    .flags      (alu_flags_s),
    .ALUControl (req_op[sel_s])
  );

  // Round-robin pointer: after serving i, prefer the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 1'b0;
    end else if (grant_s[0]) begin
      rr_ptr_r <= 1'b1;
    end else if (grant_s[1]) begin
      rr_ptr_r <= 1'b0;
    end
  end

  // Response slots: capture on accept, clear valid on drain, hold data otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 2'b00;
      rsp_result_r <= {(2*XLEN){1'b0}};
      rsp_flags_r  <= 8'h00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant_s[i]) begin
          rsp_valid_r[i]  <= 1'b1;
          rsp_result_r[i] <= alu_rd_s;
          rsp_flags_r[i]  <= alu_flags_s;
        end else if (rsp_ready[i]) begin
          rsp_valid_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Saturating count of cycles where both requested and one was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if ((req_valid == 2'b11) && (grant_s != 2'b00) && (conflict_cnt_r != CNT_MAX)) begin
      conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
    end
  end

  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_flags    = rsp_flags_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed results on
// accept, an independent monitor pops and compares when a response is consumed.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
    logic [3:0]      f;   // {S,Z,C,V}
  } vec_t;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][3:0]      req_op;
  logic [1:0][XLEN-1:0] req_a;
  logic [1:0][XLEN-1:0] req_b;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [1:0][XLEN-1:0] rsp_result;
  logic [1:0][3:0]      rsp_flags;
  logic [CNT_W-1:0]     conflict_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [35:0] q0[$];
  logic [35:0] q1[$];

  vec_t nv;
  vec_t t4a[5];
  vec_t t4b[5];
  vec_t t5[4];

  alu_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] r,
                              input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle starting at a falling edge; record what gets accepted.
  task automatic cyc(input logic [1:0] vld, input vec_t v0, input vec_t v1,
                     input logic [1:0] rrdy, input logic [1:0] exp_rdy, input string tag);
    req_valid = vld;
    req_op    = {v1.op, v0.op};
    req_a     = {v1.a, v0.a};
    req_b     = {v1.b, v0.b};
    rsp_ready = rrdy;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (req_ready[0]) q0.push_back({v0.f, v0.r});
    if (req_ready[1]) q1.push_back({v1.f, v1.r});
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    q0.delete();
    q1.delete();
    #1;
    chk({tag, " rst rsp_valid"}, 64'(rsp_valid), 64'(2'b00));
    chk({tag, " rst conflict_cnt"}, 64'(conflict_cnt), 64'd0);
    chk({tag, " rst rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, " rst rsp_flags"}, 64'(rsp_flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: a response consumed at the coming edge must match the queue head.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) chk("rsp0 unexpected", 64'd1, 64'd0);
        else chk("rsp0 {flags,result}", 64'({rsp_flags[0], rsp_result[0]}), 64'(q0.pop_front()));
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) chk("rsp1 unexpected", 64'd1, 64'd0);
        else chk("rsp1 {flags,result}", 64'({rsp_flags[1], rsp_result[1]}), 64'(q1.pop_front()));
      end
    end
  end

  initial begin
    nv = mk(ALU_ADD, 32'd0, 32'd0, 32'd0, 4'b0100);
    t4a[0] = mk(ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0,          4'b0110);
    t4a[1] = mk(ALU_SLL,  32'd1,         32'd4, 32'd16,         4'b0000);
    t4a[2] = mk(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1,          4'b0000);
    t4a[3] = mk(ALU_SRA,  32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFC,  4'b1000);
    t4a[4] = mk(ALU_OR,   32'h0F,        32'hF0, 32'hFF,        4'b0000);
    t4b[0] = mk(ALU_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF,  4'b0001);
    t4b[1] = mk(ALU_SLTU, 32'd8,         32'hFFFF_FFFF, 32'd1,  4'b0000);
    t4b[2] = mk(ALU_XOR,  32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 4'b0000);
    t4b[3] = mk(ALU_SRL,  32'h8000_0000, 32'd31, 32'd1,         4'b0000);
    t4b[4] = mk(ALU_AND,  32'h1234_5678, 32'd0, 32'd0,          4'b0100);
    t5[0]  = mk(ALU_ADD,  32'd1,   32'd100, 32'd101, 4'b0000);
    t5[1]  = mk(ALU_SUB,  32'd200, 32'd50,  32'd150, 4'b0000);
    t5[2]  = mk(ALU_SLTU, 32'd5,   32'd3,   32'd0,   4'b0100);
    t5[3]  = mk(ALU_SRL,  32'h100, 32'd4,   32'h10,  4'b0000);

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("init rsp_valid", 64'(rsp_valid), 64'(2'b00));
    chk("init conflict_cnt", 64'(conflict_cnt), 64'd0);
    rst_n = 1'b1;

    // 1: lone ADD
    cyc(2'b01, mk(ALU_ADD, 32'd20, 32'd30, 32'd50, 4'b0000), nv, 2'b11, 2'b01, "t1");
    chk("t1 rsp_valid", 64'(rsp_valid), 64'(2'b01));
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t1 idle");

    // 2: both valid straight out of reset
    do_reset("t2");
    cyc(2'b11, mk(ALU_SUB, 32'd20, 32'd20, 32'd0, 4'b0100),
               mk(ALU_XOR, 32'd8,  32'd3,  32'd11, 4'b0000), 2'b11, 2'b01, "t2 c1");
    cyc(2'b10, nv, mk(ALU_XOR, 32'd8, 32'd3, 32'd11, 4'b0000), 2'b11, 2'b10, "t2 c2");
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t2 idle");
    chk("t2 conflict_cnt", 64'(conflict_cnt), 64'd1);

    // 3: slot 0 stalled, requester 1 served every cycle
    cyc(2'b01, mk(ALU_ADD, 32'd5, 32'd6, 32'd11, 4'b0000), nv, 2'b10, 2'b01, "t3 fill");
    cyc(2'b11, mk(ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000),
               mk(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1010), 2'b10, 2'b10, "t3 s1");
    chk("t3 s1 rsp_result0", 64'(rsp_result[0]), 64'd11);
    cyc(2'b11, mk(ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000),
               mk(ALU_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 4'b0000), 2'b10, 2'b10, "t3 s2");
    chk("t3 s2 rsp_result0", 64'(rsp_result[0]), 64'd11);
    cyc(2'b11, mk(ALU_ADD, 32'd1, 32'd1, 32'd2, 4'b0000),
               mk(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001), 2'b10, 2'b10, "t3 s3");
    chk("t3 s3 rsp_result0", 64'(rsp_result[0]), 64'd11);
    chk("t3 s3 rsp_valid0", 64'(rsp_valid[0]), 64'd1);
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t3 drain1");
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t3 drain2");
    chk("t3 conflict_cnt", 64'(conflict_cnt), 64'd4);

    // 4: sustained contention, strict alternation
    do_reset("t4");
    begin
      int i0 = 0;
      int i1 = 0;
      for (int k = 0; k < 10; k++) begin
        logic [1:0] e;
        e = (k % 2 == 0) ? 2'b01 : 2'b10;
        cyc(2'b11, t4a[i0], t4b[i1], 2'b11, e, $sformatf("t4 k%0d", k));
        if (e[0]) i0++;
        else i1++;
      end
    end
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t4 idle1");
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t4 idle2");
    chk("t4 conflict_cnt", 64'(conflict_cnt), 64'd10);

    // 5: pass-through streaming on requester 0
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, t5[k], nv, 2'b11, 2'b01, $sformatf("t5 k%0d", k));
      chk($sformatf("t5 k%0d rsp_valid0", k), 64'(rsp_valid[0]), 64'd1);
    end
    chk("t6 cnt before reset", 64'(conflict_cnt), 64'd10);

    // 6: reset mid-stream, then requester 0 preferred on the first edge
    do_reset("t6");
    cyc(2'b11, mk(ALU_AND, 32'd3, 32'd1, 32'd1, 4'b0000),
               mk(ALU_OR,  32'd4, 32'd2, 32'd6, 4'b0000), 2'b11, 2'b01, "t6 c1");
    cyc(2'b10, nv, mk(ALU_OR, 32'd4, 32'd2, 32'd6, 4'b0000), 2'b11, 2'b10, "t6 c2");
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t6 idle1");
    cyc(2'b00, nv, nv, 2'b11, 2'b00, "t6 idle2");
    chk("t6 conflict_cnt", 64'(conflict_cnt), 64'd1);
    chk("q0 drained", 64'(q0.size()), 64'd0);
    chk("q1 drained", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
